sh4_fpu_lnorm: RTL and testbench
================================

// Module: sh4_fpu_lnorm
// PURPOSE
//  Left-normalizer for FPU results: counts leading zeros of a mantissa, shifts it left until the MSB is 1, and lowers the exponent by the same amount.
//  - Shift is limited so the exponent never drops below EMIN; such results are flagged denormal.
//  - It is the left-shift counterpart of the sticky-collecting right shifter used for alignment.
//  - Sits between the add/mul datapath and the rounder: 2-stage valid/ready pipeline.
// PARAMETERS
//  WIDTH   32  mantissa width, including the hidden/guard bits
//  SWIDTH  6   shift-count width; must hold the value WIDTH
//  EWIDTH  10  signed exponent width
//  EMIN    1   smallest exponent a normal result may carry
// PORTS
//  clk         in   1       clock; all state changes on the rising edge
//  rst         in   1       synchronous, active-high reset
//  flush       in   1       synchronous cancel of all in-flight entries
//  in_valid    in   1       input beat is valid
//  in_ready    out  1       block accepts the input beat this cycle
//  in_mant     in   WIDTH   unnormalized mantissa
//  in_exp      in   EWIDTH  signed exponent belonging to in_mant
//  in_sticky   in   1       sticky bit from the earlier datapath
//  out_valid   out  1       output beat is valid
//  out_ready   in   1       downstream accepts the output beat
//  out_mant    out  WIDTH   normalized mantissa
//  out_exp     out  EWIDTH  adjusted exponent
//  out_sticky  out  1       in_sticky passed through unchanged
//  out_lzc     out  SWIDTH  raw leading-zero count (WIDTH when the mantissa is zero)
//  out_zero    out  1       input mantissa was all zeros
//  out_denorm  out  1       shift was clamped by EMIN; result is denormal
// BEHAVIOUR
//  - Reset (rst=1): s1_valid=0, s2_valid=0, all data registers cleared.
//    - Hence out_valid=0 and every out_* data port reads 0.
//    - in_ready=1 in the first cycle after reset.
//  - Stage 1 registers: in_mant, in_exp, in_sticky, lzc = count of leading zeros of in_mant.
//  - Stage 2 registers:
//    - shamt = min(lzc, max(in_exp-EMIN, 0)), computed in EWIDTH+1 bits so the subtraction cannot wrap.
//    - out_mant = mant << shamt; zeros fill in at the LSB end.
//    - out_exp = in_exp - shamt.
//    - out_denorm = (shamt < lzc) and mantissa nonzero.
//    - out_lzc = lzc (unclamped).
//  - Zero mantissa: out_zero=1, out_mant=0, out_exp=0, out_lzc=WIDTH, out_denorm=0.
//  - in_exp <= EMIN with a nonzero mantissa: shamt=0, mantissa and exponent unchanged.
//    - out_denorm=1 when lzc>0.
//  - Handshake:
//    - A transfer happens when valid and ready are both high in the same cycle.
//    - s2 loads when !s2_valid or out_ready.
//    - in_ready = !s1_valid or (s2 loads).
//  - Latency: 2 cycles from input transfer to out_valid; throughput 1 beat per cycle with no stall.
//  - Stall: out_valid=1 with out_ready=0 holds every out_* port stable.
//    - At most 2 beats are buffered (s1 + s2); after that in_ready=0.
//  - Simultaneous out_ready and in_valid while full: s2 drains, s1 moves to s2, and the new beat is taken in the same cycle.
//  - Ordering: no beat is lost, duplicated or reordered under any valid/ready pattern.
//  - flush=1:
//    - Clears s1_valid and s2_valid next cycle.
//    - Any input offered in the same cycle is dropped.
//    - Data registers are don't-care.
//    - flush has lower priority than rst.
//  - Reset in mid-operation discards all in-flight beats; there is no partial output.
// STRUCTURE
//  - Shared header (defines.v): FPU exponent width, EMIN for single and double precision, mantissa widths for single and double.
//  - Sub-module sh4_fpu_lzc #(WIDTH,SWIDTH): combinational leading-zero counter.
//    - Output is data==0 ? WIDTH : number of leading zeros.
//    - Implemented as a tree, not a linear loop.
//  - The top module owns the pipeline registers, the handshake, the clamp and the barrel shift.
// TESTING (WIDTH=32, EWIDTH=10, EMIN=1)
//  - mant=0x00000100, exp=100 -> two cycles later: mant=0x80000000, exp=77, lzc=23, denorm=0.
//  - mant=0, exp=50, sticky=1 -> zero=1, mant=0, exp=0, lzc=32, sticky=1.
//  - mant=0x00010000, exp=5 -> shamt=4, mant=0x00100000, exp=1, lzc=15, denorm=1.
//  - mant=0x80000001, exp=10 -> unchanged, lzc=0; then exp=-3, mant=0x1 -> shamt=0, denorm=1.
//  - Backpressure:
//    - Stimulus: 5 back-to-back beats with out_ready=0 for cycles 2-6.
//    - Expect in_ready=0 once 2 beats are held; outputs stay stable while stalled.
//    - Expect all 5 beats to emerge in order, with no loss or duplication.
//  - Cancel: assert flush, then rst, with both stages full -> out_valid=0 next cycle; in_ready=1; the next beat comes out correctly.

Source files
------------

// File: rtl/sh4_fpu_lnorm_pkg.sv
// sh4_fpu_lnorm_pkg: shared FPU widths and exponent limits for the normalizer
package sh4_fpu_lnorm_pkg;
  localparam int FPU_EWIDTH = 10;
  localparam int EMIN_SP = 1;
  localparam int EMIN_DP = 1;
  localparam int MANT_SP = 24;
  localparam int MANT_DP = 53;
  localparam int LNORM_WIDTH = 32;
  localparam int LNORM_SWIDTH = 6;
endpackage

// File: rtl/sh4_fpu_lzc.sv
// sh4_fpu_lzc: log-depth leading-zero counter, returns WIDTH for all-zero data
module sh4_fpu_lzc import sh4_fpu_lnorm_pkg::*; #(
  parameter int WIDTH = LNORM_WIDTH,
  parameter int SWIDTH = LNORM_SWIDTH
) (
  input  logic [WIDTH-1:0]  data,
  output logic [SWIDTH-1:0] count
);
  localparam int P = 1 << SWIDTH;
  logic [P-1:0] x;
  // ones padding below the data caps the count at WIDTH for zero input
  always_comb begin
    x = {data, {(P-WIDTH){1'b1}}};
    count = '0;
    for (int k = SWIDTH-1; k >= 0; k--) begin
      if ((x >> (P - (1 << k))) == '0) begin
        count[k] = 1'b1;
        x = x << (1 << k);
      end
    end
  end
endmodule

// File: rtl/sh4_fpu_lnorm.sv
// sh4_fpu_lnorm: 2-stage valid/ready left normalizer with EMIN-clamped shift
module sh4_fpu_lnorm import sh4_fpu_lnorm_pkg::*; #(
  parameter int WIDTH = LNORM_WIDTH,
  parameter int SWIDTH = LNORM_SWIDTH,
  parameter int EWIDTH = FPU_EWIDTH,
  parameter int EMIN = EMIN_SP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_mant,
  input  logic [EWIDTH-1:0] in_exp,
  input  logic              in_sticky,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_mant,
  output logic [EWIDTH-1:0] out_exp,
  output logic              out_sticky,
  output logic [SWIDTH-1:0] out_lzc,
  output logic              out_zero,
  output logic              out_denorm
);
  logic s1_valid, s1_sticky, s2_valid, s2_sticky, s2_zero, s2_denorm, s2_load, zero;
  logic [WIDTH-1:0] s1_mant, s2_mant;
  logic [EWIDTH-1:0] s1_exp, s2_exp;
  logic [SWIDTH-1:0] lzc, s1_lzc, s2_lzc, shamt;
  logic signed [EWIDTH:0] room, lzc_x;
  sh4_fpu_lzc #(.WIDTH(WIDTH), .SWIDTH(SWIDTH)) u_lzc (.data(in_mant), .count(lzc));
  assign s2_load = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  // one extra exponent bit keeps in_exp-EMIN from wrapping
  always_comb begin
    room = $signed({s1_exp[EWIDTH-1], s1_exp}) - $signed((EWIDTH+1)'(EMIN));
    lzc_x = $signed((EWIDTH+1)'(s1_lzc));
    shamt = room < 0 ? '0 : (lzc_x < room ? s1_lzc : room[SWIDTH-1:0]);
    zero = s1_mant == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mant <= '0;
      s1_exp <= '0;
      s1_sticky <= 1'b0;
      s1_lzc <= '0;
      s2_valid <= 1'b0;
      s2_mant <= '0;
      s2_exp <= '0;
      s2_sticky <= 1'b0;
      s2_lzc <= '0;
      s2_zero <= 1'b0;
      s2_denorm <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (in_ready) s1_valid <= in_valid;
        if (s2_load) s2_valid <= s1_valid;
      end
      if (in_valid && in_ready) begin
        s1_mant <= in_mant;
        s1_exp <= in_exp;
        s1_sticky <= in_sticky;
        s1_lzc <= lzc;
      end
      if (s2_load && s1_valid) begin
        s2_mant <= zero ? '0 : s1_mant << shamt;
        s2_exp <= zero ? '0 : s1_exp - EWIDTH'(shamt);
        s2_sticky <= s1_sticky;
        s2_lzc <= s1_lzc;
        s2_zero <= zero;
        s2_denorm <= !zero && shamt < s1_lzc;
      end
    end
  end
  assign out_valid = s2_valid;
  assign out_mant = s2_mant;
  assign out_exp = s2_exp;
  assign out_sticky = s2_sticky;
  assign out_lzc = s2_lzc;
  assign out_zero = s2_zero;
  assign out_denorm = s2_denorm;
endmodule

// File: tb/tb_sh4_fpu_lnorm.sv
// tb_sh4_fpu_lnorm: scoreboarded random and directed bench for the left normalizer
module tb_sh4_fpu_lnorm;
  typedef struct packed {
    logic [31:0] mant;
    logic [9:0] exp;
    logic sticky;
    logic [5:0] lzc;
    logic zero;
    logic denorm;
  } beat_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0, in_sticky = 0;
  logic [31:0] in_mant = 0;
  logic [9:0] in_exp = 0;
  logic in_ready, out_valid, out_sticky, out_zero, out_denorm;
  logic [31:0] out_mant;
  logic [9:0] out_exp;
  logic [5:0] out_lzc;
  int tests = 0, fails = 0;
  beat_t q[$];
  beat_t exp_in;
  logic stall_prev = 0, accepted = 0, ready_seen = 1;
  logic [50:0] prev;
  sh4_fpu_lnorm dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_sticky(in_sticky), .out_valid(out_valid),
    .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp), .out_sticky(out_sticky),
    .out_lzc(out_lzc), .out_zero(out_zero), .out_denorm(out_denorm));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic beat_t model(logic [31:0] m, logic [9:0] e, logic s);
    beat_t b;
    int lz, room, sh;
    lz = 0;
    while (lz < 32 && m[31-lz] == 1'b0) lz++;
    b.sticky = s;
    b.lzc = 6'(lz);
    b.zero = (m == 0);
    if (b.zero) begin
      b.mant = 0;
      b.exp = 0;
      b.denorm = 0;
    end else begin
      room = int'($signed(e)) - 1;
      if (room < 0) room = 0;
      sh = lz < room ? lz : room;
      b.mant = m << sh;
      b.exp = 10'(int'($signed(e)) - sh);
      b.denorm = sh < lz;
    end
    return b;
  endfunction
  task automatic drive(logic [31:0] m, logic [9:0] e, logic s);
    in_mant = m;
    in_exp = e;
    in_sticky = s;
    exp_in = model(m, e, s);
  endtask
  task automatic drive_x(logic [31:0] m, logic [9:0] e, logic s, beat_t want);
    in_mant = m;
    in_exp = e;
    in_sticky = s;
    exp_in = want;
  endtask
  task automatic tick();
    beat_t e;
    @(negedge clk);
    accepted = 0;
    ready_seen = in_ready;
    if (rst || flush) begin
      q.delete();
      stall_prev = 0;
    end else begin
      check("in_ready", in_ready, (q.size() < 2) || out_ready);
      if (stall_prev) check("stall_hold", {out_mant, out_exp, out_sticky, out_lzc, out_zero, out_denorm}, prev);
      if (out_valid && q.size() == 0) check("no_beat", out_valid, 0);
      else if (out_valid && out_ready) begin
        e = q.pop_front();
        check("mant", out_mant, e.mant);
        check("exp", out_exp, e.exp);
        check("sticky", out_sticky, e.sticky);
        check("lzc", out_lzc, e.lzc);
        check("zero", out_zero, e.zero);
        check("denorm", out_denorm, e.denorm);
      end
      if (in_valid && in_ready) begin
        q.push_back(exp_in);
        accepted = 1;
      end
      stall_prev = out_valid && !out_ready;
      prev = {out_mant, out_exp, out_sticky, out_lzc, out_zero, out_denorm};
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int sent;
    logic saw_full;
    logic [31:0] m;
    tick();
    tick();
    rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", {out_mant, out_exp, out_sticky, out_lzc, out_zero, out_denorm}, 0);
    out_ready = 1;
    in_valid = 1;
    drive_x(32'h00000100, 10'd100, 0, '{32'h80000000, 10'd77, 1'b0, 6'd23, 1'b0, 1'b0});
    tick();
    in_valid = 0;
    check("lat_cycle1", out_valid, 0);
    tick();
    check("lat_cycle2", out_valid, 1);
    tick();
    in_valid = 1;
    drive_x(32'h0, 10'd50, 1, '{32'h0, 10'd0, 1'b1, 6'd32, 1'b1, 1'b0});
    tick();
    drive_x(32'h00010000, 10'd5, 0, '{32'h00100000, 10'd1, 1'b0, 6'd15, 1'b0, 1'b1});
    tick();
    drive_x(32'h80000001, 10'd10, 0, '{32'h80000001, 10'd10, 1'b0, 6'd0, 1'b0, 1'b0});
    tick();
    drive_x(32'h00000001, -10'sd3, 0, '{32'h00000001, 10'h3FD, 1'b0, 6'd31, 1'b0, 1'b1});
    tick();
    drive_x(32'h00000001, 10'd1, 1, '{32'h00000001, 10'd1, 1'b1, 6'd31, 1'b0, 1'b1});
    tick();
    in_valid = 0;
    repeat (3) tick();
    check("directed_drain", q.size(), 0);
    sent = 0;
    saw_full = 0;
    for (int c = 0; c < 40 && sent < 5; c++) begin
      out_ready = !(c >= 2 && c <= 6);
      in_valid = 1;
      drive(32'h00F00000 >> sent, 10'(40 + sent), sent[0]);
      tick();
      if (accepted) sent++;
      if (!ready_seen) saw_full = 1;
    end
    in_valid = 0;
    out_ready = 1;
    repeat (4) tick();
    check("bp_sent", sent, 5);
    check("bp_full", saw_full, 1);
    check("bp_drain", q.size(), 0);
    out_ready = 0;
    in_valid = 1;
    drive(32'h1234, 10'd20, 0);
    repeat (3) tick();
    flush = 1;
    drive(32'h5678, 10'd20, 1);
    tick();
    flush = 0;
    in_valid = 0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    in_valid = 1;
    drive(32'h9ABC, 10'd20, 0);
    repeat (3) tick();
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    out_ready = 1;
    in_valid = 1;
    drive(32'h00000300, 10'd30, 1);
    tick();
    in_valid = 0;
    repeat (3) tick();
    check("cancel_drain", q.size(), 0);
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 63) == 0;
      m = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) m = 0;
      drive(m, $urandom_range(0, 7) == 0 ? 10'($urandom) : 10'($urandom_range(0, 120) - 20), 1'($urandom));
      tick();
    end
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    for (int c = 0; c < 20 && q.size() > 0; c++) tick();
    check("random_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
